// File: rtl/blake3_pkg.sv
// Shared types and constants for the BLAKE3 chunk front end.
//   BLOCK_WORDS / BLOCK_BYTES / CHUNK_BYTES : block and chunk geometry
//   msg_block_t     : one 16-word message block, word 0 in the low 32 bits
//   feeder_state_t  : chunk_msg_feeder FSM states
//   last_word_mask  : byte-enable mask for the final, possibly partial, word
// The hash IV constants remain in the existing define file.
package blake3_pkg;

    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_BYTES = 64;
    localparam int CHUNK_BYTES = 1024;

    typedef logic [15:0][31:0] msg_block_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_HASH
    } feeder_state_t;

    // Words are little-endian, so the surviving bytes of a partial word are
    // always the low ones.
    function automatic logic [31:0] last_word_mask(input logic [31:0] byte_num);
        logic [31:0] mask;
        case (byte_num[1:0])
            2'd1:    mask = 32'h0000_00ff;
            2'd2:    mask = 32'h0000_ffff;
            2'd3:    mask = 32'h00ff_ffff;
            default: mask = 32'hffff_ffff;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/chunk_block_buffer.sv
// 16-word message block register with an auto-incrementing write index.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : zero the block and return the index to word 0
//   wr_en_i     : store wr_data_i & wr_mask_i at the current index, advance
//   wr_data_i   : incoming message word
//   wr_mask_i   : byte mask applied to the stored word
//   msg_o       : current block contents
//   idx_o       : index the next write will use
module chunk_block_buffer
    import blake3_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr_i,
    input  logic                           wr_en_i,
    input  logic [31:0]                    wr_data_i,
    input  logic [31:0]                    wr_mask_i,
    output msg_block_t                     msg_o,
    output logic [$clog2(BLOCK_WORDS)-1:0] idx_o
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);

    msg_block_t       msg_q, msg_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        msg_d = msg_q;
        idx_d = idx_q;
        if (clr_i) begin
            msg_d = '0;
            idx_d = '0;
        end else if (wr_en_i) begin
            msg_d[idx_q] = wr_data_i & wr_mask_i;
            idx_d        = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q <= '0;
            idx_q <= '0;
        end else begin
            msg_q <= msg_d;
            idx_q <= idx_d;
        end
    end

    assign msg_o = msg_q;
    assign idx_o = idx_q;

endmodule

// File: rtl/chunk_msg_feeder.sv
// Source-side driver for the BLAKE3 ChunkHasher message interface. Packs a
// valid/ready word stream into zero-padded 16-word blocks, strobes each block
// into the hasher, paces on the hasher's address/valid feedback and signals
// when the chunk hash is valid.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_i, byte_num_i : begin a message of byte_num_i bytes (IDLE only)
//   word_i, word_vld_i, word_rdy_o : little-endian word stream handshake
//   msg_o, byte_num_o, update_o    : block, length and strobe to the hasher
//   addr_i, hash_vld_i  : hasher address and hash-valid feedback
//   busy_o, done_o, err_o : not idle / chunk hash valid pulse / sticky error
// Build option FEEDER_TIMEOUT_EN: when defined, a watchdog of TIMEOUT_CYC
// cycles guards WAIT_ACK and WAIT_HASH; otherwise those states wait forever.
//
// state        | meaning
// IDLE         | waiting for start_i
// FILL         | accepting words into the block buffer
// ISSUE        | update_o pulse, snapshot of the hasher address
// WAIT_ACK     | hasher consuming a non-final block
// WAIT_HASH    | final block issued, waiting for the hash-valid rising edge
module chunk_msg_feeder
    import blake3_pkg::*;
#(
    parameter int MAX_BYTES   = CHUNK_BYTES,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [31:0]       byte_num_i,
    input  logic [31:0]       word_i,
    input  logic              word_vld_i,
    output logic              word_rdy_o,
    output msg_block_t        msg_o,
    output logic [31:0]       byte_num_o,
    output logic              update_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              hash_vld_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int IDX_W     = $clog2(BLOCK_WORDS);
    localparam int BLK_WORDS = BLOCK_BYTES / 4;

    feeder_state_t     state_q, state_d;
    logic [31:0]       byte_num_q;
    logic [9:0]        word_cnt_q;
    logic [ADDR_W-1:0] addr_snap_q;
    logic              hash_vld_q;
    logic              err_q;

    msg_block_t        buf_msg;
    logic [IDX_W-1:0]  buf_idx;
    logic              buf_clr;

    logic [9:0]        words_total;
    logic              start_ok;
    logic              accept;
    logic              last_word;
    logic [31:0]       wr_mask;
    logic              block_end;
    logic              msg_last;
    logic              ack_seen;
    logic              hash_rise;
    logic              timeout;

    // Lengths above MAX_BYTES never leave IDLE, so the low 11 bits suffice.
    assign words_total = 10'(({1'b0, byte_num_q[10:0]} + 12'd3) >> 2);
    assign start_ok    = start_i && (byte_num_i <= 32'(MAX_BYTES));
    assign accept      = (state_q == ST_FILL) && word_vld_i;
    assign last_word   = (word_cnt_q + 10'd1) == words_total;
    assign wr_mask     = last_word ? last_word_mask(byte_num_q) : 32'hffff_ffff;
    assign block_end   = accept && ((buf_idx == IDX_W'(BLK_WORDS - 1)) || last_word);
    assign msg_last    = word_cnt_q == words_total;
    assign ack_seen    = (addr_i != addr_snap_q) || hash_vld_i;
    assign hash_rise   = hash_vld_i && !hash_vld_q;
    assign buf_clr     = ((state_q == ST_IDLE) && start_ok) ||
                         ((state_q == ST_WAIT_ACK) && (state_d == ST_FILL));

`ifdef FEEDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q;

    // Reloaded on every state change, so it measures time spent in the
    // current wait state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (state_d != state_q) begin
            tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
        end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - 1'b1;
        end
    end

    assign timeout = ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_HASH)) &&
                     (tmo_q == '0);
`else
    // Watchdog compiled out; TIMEOUT_CYC is still referenced so both builds
    // share one parameter list.
    assign timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    chunk_block_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (buf_clr),
        .wr_en_i   (accept),
        .wr_data_i (word_i),
        .wr_mask_i (wr_mask),
        .msg_o     (buf_msg),
        .idx_o     (buf_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = (byte_num_i == 32'd0) ? ST_ISSUE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (block_end) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = msg_last ? ST_WAIT_HASH : ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ack_seen) begin
                    state_d = ST_FILL;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_HASH: begin
                if (hash_rise || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_rdy_o = (state_q == ST_FILL);
        update_o   = (state_q == ST_ISSUE);
        busy_o     = (state_q != ST_IDLE);
        done_o     = (state_q == ST_WAIT_HASH) && hash_rise;
        err_o      = err_q;
        msg_o      = buf_msg;
        byte_num_o = byte_num_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_num_q  <= '0;
            word_cnt_q  <= '0;
            addr_snap_q <= '0;
            hash_vld_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            hash_vld_q <= hash_vld_i;
            if ((state_q == ST_IDLE) && start_i) begin
                byte_num_q <= byte_num_i;
                err_q      <= !start_ok;
                word_cnt_q <= '0;
            end else if (accept) begin
                word_cnt_q <= word_cnt_q + 10'd1;
            end
            if (state_q == ST_ISSUE) begin
                addr_snap_q <= addr_i;
            end
            if (((state_q == ST_WAIT_ACK) && timeout && !ack_seen) ||
                ((state_q == ST_WAIT_HASH) && timeout && !hash_rise)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chunk_msg_feeder.sv
module tb_chunk_msg_feeder;
    import blake3_pkg::*;

`ifdef FEEDER_TIMEOUT_EN
    localparam int TMO       = 16;
    localparam int HD_DIRECT = 10;
`else
    localparam int TMO       = 4096;
    localparam int HD_DIRECT = 20;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] byte_num;
    logic [31:0] word;
    logic        word_vld;
    logic        word_rdy;
    msg_block_t  msg;
    logic [31:0] byte_num_o;
    logic        update;
    logic [9:0]  addr = '0;
    logic        hash_vld = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    // written by the hasher stub / monitors only
    int            upd_total = 0;
    int            rdy_viol  = 0;
    int            done_cyc  = 0;
    int            rdy_cyc   = 0;
    logic [511:0]  got_q[$];
    int            addr_cd = 0;
    int            hash_cd = 0;
    int            hv_hold = 0;
    bit            ack_wait = 1'b0;

    // written by the main sequence only
    int msg_base   = 0;
    int exp_blocks = 1;
    int hash_delay = 0;
    int ack_delay  = 0;
    int done_base  = 0;
    int viol_base  = 0;
    int rdy_base   = 0;
    logic [31:0] mw [256];

    chunk_msg_feeder #(.TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .byte_num_i (byte_num),
        .word_i     (word),
        .word_vld_i (word_vld),
        .word_rdy_o (word_rdy),
        .msg_o      (msg),
        .byte_num_o (byte_num_o),
        .update_o   (update),
        .addr_i     (addr),
        .hash_vld_i (hash_vld),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected block b of an n-byte message, built byte by byte.
    function automatic logic [511:0] model_block(input int n, input int b);
        logic [511:0] r = '0;
        for (int i = 0; i < 64; i++) begin
            int p = b * 64 + i;
            if (p < n) r[i*8 +: 8] = mw[p/4][(p%4)*8 +: 8];
        end
        return r;
    endfunction

    // Hasher stub: records each block, advances Addr some cycles after a
    // non-final block, raises Vld some cycles after the final one.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            addr_cd  = 0;
            hash_cd  = 0;
            hv_hold  = 0;
            hash_vld = 1'b0;
            ack_wait = 1'b0;
        end else begin
            if (ack_wait && word_rdy) rdy_viol++;
            if (addr_cd > 0) begin
                addr_cd--;
                if (addr_cd == 0) begin
                    addr     = addr + 10'd64;
                    ack_wait = 1'b0;
                end
            end
            if (hash_cd > 0) begin
                hash_cd--;
                if (hash_cd == 0) begin
                    hash_vld = 1'b1;
                    hv_hold  = int'($urandom_range(0, 3));
                end
            end else if (hash_vld) begin
                if (hv_hold > 0) hv_hold--;
                else hash_vld = 1'b0;
            end
            if (update) begin
                got_q.push_back(msg);
                upd_total++;
                if (upd_total - msg_base >= exp_blocks) begin
                    hash_cd = (hash_delay > 0) ? hash_delay : int'($urandom_range(2, 12));
                end else begin
                    addr_cd  = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 6));
                    ack_wait = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cyc++;
        if (word_rdy) rdy_cyc++;
    end

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mw[i] = $urandom;
    endtask

    task automatic start_msg(input int n);
        msg_base   = upd_total;
        exp_blocks = (n == 0) ? 1 : (n + 63) / 64;
        done_base  = done_cyc;
        viol_base  = rdy_viol;
        rdy_base   = rdy_cyc;
        @(posedge clk);
        #1;
        start    = 1'b1;
        byte_num = 32'(n);
        @(posedge clk);
        #1;
        start    = 1'b0;
        byte_num = $urandom;
    endtask

    task automatic drive_words(input int total, input int stop_upd);
        int wi  = 0;
        bit acc = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (acc) begin
                if ((wi % 16) == 15 || wi == total - 1) chk("upd_after_last_word", update, 1);
                wi++;
            end
            acc = 1'b0;
            if (wi >= total) break;
            if (stop_upd > 0 && (upd_total - msg_base) >= stop_upd) break;
            word_vld = ($urandom_range(0, 3) != 0);
            word     = word_vld ? mw[wi] : $urandom;
            acc      = word_vld && word_rdy;
        end
        word_vld = 1'b0;
        if (stop_upd == 0) chk("words_accepted", wi, total);
    endtask

    task automatic finish_msg(input int n);
        for (int c = 0; c < 3000 && done_cyc == done_base; c++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk("done_cycles", done_cyc - done_base, 1);
        chk("block_count", upd_total - msg_base, exp_blocks);
        for (int b = 0; b < exp_blocks; b++) begin
            if (msg_base + b < got_q.size())
                chk("block_data", got_q[msg_base + b], model_block(n, b));
        end
        chk("busy_after_done", busy, 0);
        chk("err_after_done", err, 0);
        chk("byte_num_o", byte_num_o, n);
        chk("rdy_in_wait_ack", rdy_viol - viol_base, 0);
        if (n == 0) chk("rdy_zero_len", rdy_cyc - rdy_base, 0);
    endtask

    task automatic run_msg(input int n);
        start_msg(n);
        drive_words((n + 3) / 4, 0);
        finish_msg(n);
    endtask

    task automatic run_oversize(input int n);
        start_msg(n);
        repeat (4) @(negedge clk);
        chk("oversize_err", err, 1);
        chk("oversize_busy", busy, 0);
        chk("oversize_upd", upd_total - msg_base, 0);
        chk("oversize_rdy", rdy_cyc - rdy_base, 0);
        chk("oversize_byte_num_o", byte_num_o, n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, word_rdy, 0);
        chk({tag, "_upd"}, update, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_msg"}, msg, '0);
        chk({tag, "_byte_num"}, byte_num_o, 0);
    endtask

    initial begin
        int upd_before;
        rst_n    = 1'b0;
        start    = 1'b0;
        byte_num = '0;
        word     = '0;
        word_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 64 bytes, counting pattern, slow hash
        for (int i = 0; i < 256; i++) mw[i] = i;
        hash_delay = HD_DIRECT;
        run_msg(64);
        hash_delay = 0;

        // full chunk, hasher acknowledges five cycles after each block
        fill_random();
        ack_delay = 5;
        run_msg(1024);
        ack_delay = 0;

        // partial trailing word
        for (int i = 0; i < 256; i++) mw[i] = 32'h1122_3344;
        run_msg(70);

        // empty message, then oversize
        fill_random();
        run_msg(0);
        run_oversize(1028);

        // reset while the hasher is consuming block 3
        fill_random();
        ack_delay = 8;
        start_msg(1024);
        drive_words(256, 3);
        @(posedge clk);
        #1;
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ack_delay = 0;
        upd_before = upd_total;
        repeat (10) @(negedge clk);
        chk("no_upd_after_reset", upd_total - upd_before, 0);
        fill_random();
        run_msg(64);

        for (int t = 0; t < 14; t++) begin
            int n;
            case ($urandom_range(0, 7))
                0:       n = int'($urandom_range(0, 4));
                1:       n = int'($urandom_range(63, 65));
                2:       n = 1024;
                3:       n = int'($urandom_range(1025, 5000));
                default: n = int'($urandom_range(0, 1024));
            endcase
            if (n > 1024) run_oversize(n);
            else begin
                fill_random();
                run_msg(n);
            end
        end

`ifdef FEEDER_TIMEOUT_EN
        // hasher never acknowledges block 1: watchdog must abort
        fill_random();
        ack_delay = 100000;
        start_msg(128);
        drive_words(32, 1);
        for (int c = 0; c < 200 && err !== 1'b1; c++) @(negedge clk);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_done", done_cyc - done_base, 0);
        chk("tmo_blocks", upd_total - msg_base, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
